// File: rtl/bip_program_memory.sv
// Instruction-fetch program memory with a byte-stream image loader that holds the CPU in reset until a good load.
// Optional build macro PROGMEM_CHECKSUM_EN adds a trailing XOR checksum byte to the image format.
module bip_program_memory #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_program,
    output logic [15:0]       data,
    output logic              cpu_reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    output logic              load_ready,
    output logic              loaded,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);
    localparam int unsigned CW = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CNT_HI  = 3'd1,
        CNT_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
`ifdef PROGMEM_CHECKSUM_EN
        CHK     = 3'd5,
`endif
        DONE    = 3'd6,
        ERR     = 3'd7
    } state_t;

`ifdef PROGMEM_CHECKSUM_EN
    localparam state_t FIN_STATE = CHK;
`else
    localparam state_t FIN_STATE = DONE;
`endif

    state_t          state_q, state_d;
    logic [7:0]      hi_q, hi_d;
    logic [7:0]      cnt_hi_q, cnt_hi_d;
    logic [CW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   word_count_q, word_count_d;
    logic            loaded_q, loaded_d;
    logic            err_q, err_d;
    logic            cpu_reset_q, cpu_reset_d;
`ifdef PROGMEM_CHECKSUM_EN
    logic [7:0]      chk_q, chk_d;
`endif
    logic            accept_c;
    logic            mem_we_c;
    logic [15:0]     count_c;
    logic [15:0]     mem [DEPTH];

    // Loader FSM: header parse, word assembly, and status derived from the next state
    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        cnt_hi_d     = cnt_hi_q;
        wr_ptr_d     = wr_ptr_q;
        word_count_d = word_count_q;
        mem_we_c     = 1'b0;
        load_ready   = 1'b0;
`ifdef PROGMEM_CHECKSUM_EN
        chk_d        = chk_q;
`endif
        case (state_q)
            CNT_HI, CNT_LO, DATA_HI, DATA_LO: load_ready = !load_start;
`ifdef PROGMEM_CHECKSUM_EN
            CHK:                              load_ready = !load_start;
`endif
            default:                          load_ready = 1'b0;
        endcase
        accept_c = load_valid && load_ready;
        count_c  = {cnt_hi_q, load_byte};

        if (load_start) begin
            state_d      = CNT_HI;
            wr_ptr_d     = '0;
            word_count_d = '0;
`ifdef PROGMEM_CHECKSUM_EN
            chk_d        = 8'h00;
`endif
        end else begin
`ifdef PROGMEM_CHECKSUM_EN
            if (accept_c) chk_d = chk_q ^ load_byte;
`endif
            case (state_q)
                IDLE: state_d = CNT_HI;
                CNT_HI: if (accept_c) begin
                    cnt_hi_d = load_byte;
                    state_d  = CNT_LO;
                end
                CNT_LO: if (accept_c) begin
                    if (count_c > 16'(DEPTH)) begin
                        state_d = ERR;
                    end else begin
                        word_count_d = CW'(count_c);
                        state_d      = (count_c == 16'h0000) ? FIN_STATE : DATA_HI;
                    end
                end
                DATA_HI: if (accept_c) begin
                    hi_d    = load_byte;
                    state_d = DATA_LO;
                end
                DATA_LO: if (accept_c) begin
                    mem_we_c = 1'b1;
                    wr_ptr_d = wr_ptr_q + CW'(1);
                    state_d  = (wr_ptr_d == word_count_q) ? FIN_STATE : DATA_HI;
                end
`ifdef PROGMEM_CHECKSUM_EN
                CHK: if (accept_c) begin
                    state_d = (load_byte == chk_q) ? DONE : ERR;
                end
`endif
                default: state_d = state_q;
            endcase
        end

        // Only DONE releases the CPU; load_start re-enters CNT_HI so it re-asserts reset
        loaded_d    = (state_d == DONE);
        err_d       = (state_d == ERR);
        cpu_reset_d = (state_d != DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            hi_q         <= 8'h00;
            cnt_hi_q     <= 8'h00;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
            loaded_q     <= 1'b0;
            err_q        <= 1'b0;
            cpu_reset_q  <= 1'b1;
`ifdef PROGMEM_CHECKSUM_EN
            chk_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            cnt_hi_q     <= cnt_hi_d;
            wr_ptr_q     <= wr_ptr_d;
            word_count_q <= word_count_d;
            loaded_q     <= loaded_d;
            err_q        <= err_d;
            cpu_reset_q  <= cpu_reset_d;
`ifdef PROGMEM_CHECKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end

    // Storage array has no reset; contents survive load_start and reset
    always_ff @(posedge clk) begin
        if (mem_we_c) mem[wr_ptr_q[ADDR_W-1:0]] <= {hi_q, load_byte};
    end

    // Zero-latency fetch; anything outside a completed image reads as HLT
    always_comb begin
        data = 16'h0000;
        if (loaded_q && (CW'(addr_program) < word_count_q)) data = mem[addr_program];
    end

    assign cpu_reset  = cpu_reset_q;
    assign loaded     = loaded_q;
    assign err        = err_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_bip_program_memory.sv
// Self-checking bench for bip_program_memory: directed images plus random images against an image-level model.
module tb_bip_program_memory;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DEPTH  = 2048;

    typedef logic [7:0] byte_q_t[$];

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] addr_program;
    logic [15:0]       data;
    logic              cpu_reset;
    logic              load_start;
    logic              load_valid;
    logic [7:0]        load_byte;
    logic              load_ready;
    logic              loaded;
    logic              err;
    logic [ADDR_W:0]   word_count;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_mem [DEPTH];
    int          exp_cnt;
    bit          exp_err;

    bip_program_memory #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .addr_program(addr_program), .data(data),
        .cpu_reset(cpu_reset), .load_start(load_start), .load_valid(load_valid),
        .load_byte(load_byte), .load_ready(load_ready), .loaded(loaded),
        .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Image-level reference: parse header, collect words, verify optional checksum
    task automatic model_image(input byte_q_t img);
        int n;
        logic [7:0] x;
        n = int'({img[0], img[1]});
        exp_err = (n > int'(DEPTH));
        exp_cnt = exp_err ? 0 : n;
        if (!exp_err)
            for (int i = 0; i < n; i++) exp_mem[i] = {img[2 + 2 * i], img[3 + 2 * i]};
`ifdef PROGMEM_CHECKSUM_EN
        x = 8'h00;
        for (int i = 0; i < img.size() - 1; i++) x = x ^ img[i];
        if (!exp_err && x != img[img.size() - 1]) exp_err = 1'b1;
`else
        x = 8'h00;
`endif
    endtask

    function automatic byte_q_t with_chk(input byte_q_t q);
        byte_q_t r;
        logic [7:0] x;
        r = q;
        x = 8'h00;
        foreach (q[i]) x = x ^ q[i];
`ifdef PROGMEM_CHECKSUM_EN
        r.push_back(x);
`endif
        return r;
    endfunction

    task automatic start_load();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Present one byte; returns at the negedge after the accepting edge
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        t = 0;
        load_valid = 1'b1;
        load_byte  = b;
        #1;
        while (!load_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 50) begin
            total++;
            bad++;
            $display("FAIL send_byte_timeout: load_ready=%b required 1", load_ready);
        end
        @(negedge clk);
        load_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic send_image(input byte_q_t img, input bit gap, input int skip_last);
        for (int i = 0; i < img.size() - skip_last; i++) send_byte(img[i], gap);
    endtask

    task automatic test_reset();
        reset = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_byte = 8'h00; addr_program = '0;
        repeat (2) @(negedge clk);
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
        total++; if (loaded !== 1'b0) begin bad++; $display("FAIL rst_loaded: got %b want 0", loaded); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
        total++; if (word_count !== '0) begin bad++; $display("FAIL rst_word_count: got %0d want 0", word_count); end
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL rst_load_ready: got %b want 0", load_ready); end
        total++; if (data !== 16'h0000) begin bad++; $display("FAIL rst_data: got %h want 0000", data); end
        reset = 1'b1;
        #1;
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL idle_load_ready: got %b want 0", load_ready); end
        @(negedge clk);
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL cnt_hi_load_ready: got %b want 1", load_ready); end
    endtask

    task automatic test_fixed_image(input bit gap);
        byte_q_t img;
        logic [15:0] e;
        img = with_chk({8'h00, 8'h04, 8'h10, 8'h01, 8'h28, 8'h05, 8'h08, 8'h08, 8'h00, 8'h00});
        model_image(img);
        start_load();
        send_image(img, gap, 1);
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL pre_last_cpu_reset gap=%0d: got %b want 1", gap, cpu_reset); end
        total++; if (data !== 16'h0000) begin bad++; $display("FAIL loading_data gap=%0d: got %h want 0000", gap, data); end
        send_byte(img[img.size() - 1], 1'b0);
        total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL done_cpu_reset gap=%0d: got %b want 0", gap, cpu_reset); end
        total++; if (loaded !== 1'b1) begin bad++; $display("FAIL done_loaded gap=%0d: got %b want 1", gap, loaded); end
        total++; if (int'(word_count) != exp_cnt) begin bad++; $display("FAIL done_word_count gap=%0d: got %0d want %0d", gap, word_count, exp_cnt); end
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL done_load_ready gap=%0d: got %b want 0", gap, load_ready); end
        for (int a = 0; a < 6; a++) begin
            addr_program = ADDR_W'(a);
            #1;
            e = (a < exp_cnt) ? exp_mem[a] : 16'h0000;
            total++; if (data !== e) begin bad++; $display("FAIL fixed_data gap=%0d addr=%0d: got %h want %h", gap, a, data, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_oversize();
        start_load();
        send_byte(8'h08, 1'b0);
        send_byte(8'h01, 1'b0);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL ovr_err: got %b want 1", err); end
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL ovr_cpu_reset: got %b want 1", cpu_reset); end
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL ovr_load_ready: got %b want 0", load_ready); end
        total++; if (loaded !== 1'b0) begin bad++; $display("FAIL ovr_loaded: got %b want 0", loaded); end
        @(negedge clk);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL ovr_err_sticky: got %b want 1", err); end
        start_load();
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL ovr_clear_err: got %b want 0", err); end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL ovr_clear_ready: got %b want 1", load_ready); end
    endtask

`ifdef PROGMEM_CHECKSUM_EN
    task automatic test_bad_checksum();
        byte_q_t img;
        img = {8'h00, 8'h04, 8'h10, 8'h01, 8'h28, 8'h05, 8'h08, 8'h08, 8'h00, 8'h00, 8'h39};
        start_load();
        send_image(img, 1'b0, 0);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL chk_err: got %b want 1", err); end
        total++; if (loaded !== 1'b0) begin bad++; $display("FAIL chk_loaded: got %b want 0", loaded); end
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL chk_cpu_reset: got %b want 1", cpu_reset); end
    endtask
`endif

    task automatic test_abort();
        byte_q_t img;
        start_load();
        send_image({8'h00, 8'h04, 8'h10, 8'h01, 8'h28}, 1'b0, 0);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_byte  = 8'h05;
        #1;
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL abort_ready: got %b want 0", load_ready); end
        @(negedge clk);
        load_start = 1'b0;
        load_valid = 1'b0;
        total++; if (word_count !== '0) begin bad++; $display("FAIL abort_word_count: got %0d want 0", word_count); end
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL abort_cpu_reset: got %b want 1", cpu_reset); end
        img = with_chk({8'h00, 8'h01, 8'hAB, 8'hCD});
        send_image(img, 1'b0, 0);
        total++; if (word_count !== 12'd1) begin bad++; $display("FAIL abort_new_count: got %0d want 1", word_count); end
        total++; if (loaded !== 1'b1) begin bad++; $display("FAIL abort_new_loaded: got %b want 1", loaded); end
        addr_program = '0;
        #1;
        total++; if (data !== 16'hABCD) begin bad++; $display("FAIL abort_data0: got %h want abcd", data); end
        addr_program = 11'd1;
        #1;
        total++; if (data !== 16'h0000) begin bad++; $display("FAIL abort_data1: got %h want 0000", data); end
        @(negedge clk);
    endtask

    task automatic test_random();
        byte_q_t img;
        logic [15:0] e;
        int n;
        for (int it = 0; it < 6; it++) begin
            n = (it == 0) ? 0 : int'($urandom_range(1, 24));
            img = {8'(n >> 8), 8'(n)};
            for (int i = 0; i < 2 * n; i++) img.push_back(8'($urandom));
            img = with_chk(img);
            model_image(img);
            start_load();
            foreach (img[i]) send_byte(img[i], 1'($urandom_range(0, 1)));
            total++; if (loaded !== !exp_err) begin bad++; $display("FAIL rnd_loaded it=%0d: got %b want %b", it, loaded, !exp_err); end
            total++; if (int'(word_count) != exp_cnt) begin bad++; $display("FAIL rnd_word_count it=%0d: got %0d want %0d", it, word_count, exp_cnt); end
            for (int a = 0; a < n + 3; a++) begin
                addr_program = ADDR_W'(a);
                #1;
                e = (!exp_err && a < exp_cnt) ? exp_mem[a] : 16'h0000;
                total++; if (data !== e) begin bad++; $display("FAIL rnd_data it=%0d addr=%0d: got %h want %h", it, a, data, e); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        byte_q_t img;
        img = with_chk({8'h00, 8'h01, 8'h55, 8'hAA});
        start_load();
        send_image(img, 1'b0, 0);
        total++; if (loaded !== 1'b1) begin bad++; $display("FAIL arst_pre_loaded: got %b want 1", loaded); end
        #1 reset = 1'b0;
        #1;
        total++; if (loaded !== 1'b0) begin bad++; $display("FAIL arst_run_loaded: got %b want 0", loaded); end
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL arst_run_cpu_reset: got %b want 1", cpu_reset); end
        @(negedge clk);
        reset = 1'b1;
        send_image({8'h00, 8'h02, 8'h12, 8'h34}, 1'b0, 0);
        #1 reset = 1'b0;
        #1;
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL arst_load_ready: got %b want 0", load_ready); end
        total++; if (word_count !== '0) begin bad++; $display("FAIL arst_word_count: got %0d want 0", word_count); end
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL arst_cpu_reset: got %b want 1", cpu_reset); end
        @(negedge clk);
        reset = 1'b1;
        img = with_chk({8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
        send_image(img, 1'b0, 0);
        total++; if (word_count !== 12'd2) begin bad++; $display("FAIL arst_restart_count: got %0d want 2", word_count); end
        total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL arst_restart_cpu_reset: got %b want 0", cpu_reset); end
        addr_program = 11'd1;
        #1;
        total++; if (data !== 16'hCCDD) begin bad++; $display("FAIL arst_restart_data: got %h want ccdd", data); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fixed_image(1'b0);
        test_fixed_image(1'b1);
        test_oversize();
`ifdef PROGMEM_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_abort();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bip_program_memory.md
# bip_program_memory

Program-memory responder for the accumulator CPU's instruction-fetch port. Holds up to DEPTH 16-bit instruction words, returns the word at `addr_program` on `data` combinationally, and keeps the CPU in reset until a program image has been streamed in over a byte-wide valid/ready loader port. Sits between the board-level loader (UART or bench) and `cpu`, driving the CPU's `data` and `reset` inputs.

## Interface
- `ADDR_W`, 11: fetch address width; matches the CPU's `addr_program`.
- `DEPTH`, 2048: number of instruction words; must be ≤ 2^ADDR_W.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `addr_program` in ADDR_W: fetch address from the CPU.
- `data` out 16: instruction word for `addr_program`.
- `cpu_reset` out 1: active-high reset to the CPU; deasserts only after a good load.
- `load_start` in 1: one-cycle pulse; aborts any load and restarts from the count header.
- `load_valid` in 1: loader byte valid.
- `load_byte` in 8: loader byte.
- `load_ready` out 1: block accepts a byte this cycle.
- `loaded` out 1: image complete and accepted.
- `err` out 1: image rejected; sticky until `load_start` or reset.
- `word_count` out ADDR_W+1: number of words loaded.

## Operation
- Image format: count high byte, count low byte (16-bit big-endian N), then N words, each high byte then low byte, written to addresses 0..N-1.
- FSM states: IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHK (only with macro), DONE, ERR.
- IDLE → CNT_HI unconditionally on the next edge.
- The remaining transitions advance only on an accepted byte, i.e. `load_valid && load_ready`.
  - CNT_HI → CNT_LO.
  - CNT_LO → ERR if N > DEPTH; otherwise DATA_HI if N > 0, else CHK/DONE.
- DATA_HI latches the high byte. DATA_LO writes `{hi, load_byte}` to `mem[wr_ptr]` and increments `wr_ptr`. After the Nth word the FSM goes to CHK/DONE, else back to DATA_HI.
- `load_ready` = state ∈ {CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHK} && !`load_start`. It is combinational, so a byte is never consumed in a `load_start` cycle.
- Fetch path:
  - `data` = `mem[addr_program]` when `loaded` && `addr_program` < `word_count`.
  - Otherwise `data` = 16'h0000 (HLT), including addresses beyond the image and during loading.
- `load_start`, from any state: the next state is CNT_HI. `wr_ptr`, `word_count`, `loaded` and `err` are cleared, and `cpu_reset` is set. This holds mid-load and while the CPU is running. Memory contents are not cleared.
- DONE: `loaded`=1, `cpu_reset`=0. Further bytes are not accepted (`load_ready`=0).
- ERR: `err`=1, `cpu_reset` stays 1, `loaded`=0. The block stays in ERR until `load_start`.

## Timing
- Reset values: state=IDLE, `cpu_reset`=1, `loaded`=0, `err`=0, `word_count`=0, `wr_ptr`=0, `load_ready`=0, `data`=0.
- `load_ready` first rises the cycle after `reset` releases (IDLE→CNT_HI).
- Memory write occurs on the edge that accepts a DATA_LO byte. The word is fetchable once `loaded`=1.
- `loaded`, `err` and `cpu_reset` are registered and update on the edge that enters DONE/ERR. So the CPU leaves reset one cycle after the final byte is accepted.
- `data` is combinational from `addr_program`: zero-cycle fetch latency, matching the CPU's same-cycle instruction sampling.
- `word_count` updates on the edge accepting CNT_LO, if valid.
- Asynchronous `reset` assertion mid-load or mid-run returns every register to its reset value immediately.

## Configuration
- `PROGMEM_CHECKSUM_EN` defined:
  - After the last data word (or after CNT_LO when N=0), the FSM enters CHK and accepts one checksum byte.
  - A running XOR covers all image bytes including the count bytes.
  - If the checksum byte equals that XOR → DONE, else → ERR.
- Not defined: the CHK state and checksum logic are absent; the final word (or CNT_LO with N=0) goes directly to DONE.

## Test plan
- Load `00 04 10 01 28 05 08 08 00 00` (+`38` with macro):
  - `cpu_reset` falls one cycle after the last byte; `loaded`=1, `word_count`=4.
  - `addr_program`=0/1/2/3 → `data`=16'h1001/16'h2805/16'h0808/16'h0000.
  - `addr_program`=5 → 16'h0000.
- Count header `08 01` (2049 > DEPTH) → `err`=1 on the CNT_LO edge, `cpu_reset` stays 1, `load_ready`=0; `load_start` → `err`=0, `load_ready`=1 next cycle.
- Same image with checksum byte `39` (macro on) → `err`=1, `loaded`=0, `cpu_reset`=1. With the macro off, the 4-word image reaches DONE without any checksum byte.
- `load_start` asserted after 3 data bytes, with `load_valid` high in that same cycle → that byte is not accepted. A fresh image `00 01 AB CD` then loads: `word_count`=1, `data`@0 = 16'hABCD, `data`@1 = 0.
- `load_valid` toggled every other cycle during the image → identical final contents to the back-to-back load.
- Async `reset` low mid-DATA_HI → `cpu_reset`=1, `loaded`=0, `load_ready`=0 immediately; after release, the load restarts from CNT_HI.
